// File: rtl/ram_slot_scheduler.sv
// ram_slot_scheduler: time-slot arbiter sharing one single-port RAM between video, CPU and DMA
module ram_slot_scheduler #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 8,
    parameter int SLOT_LEN    = 25,
    parameter int RAM_LATENCY = 1
) (
    input  logic              CLK100MHZ,
    input  logic              RESET,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              slot_phase
);
    localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(SLOT_LEN - 1);
    localparam logic [CW-1:0] DONE_C = CW'(RAM_LATENCY + 1);

    typedef enum logic [1:0] {NONE, VID, CPU, DMA} owner_t;

    owner_t            owner, owner_nxt;
    logic [CW-1:0]     c;
    logic              start, done, own_we, issue_we;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_wdata;

    // slot cycle counter; phase flips each time the counter wraps
    always_ff @(posedge CLK100MHZ or posedge RESET)
        if (RESET) begin
            c          <= '0;
            slot_phase <= 1'b0;
        end else begin
            c <= (c == LAST_C) ? '0 : c + 1'b1;
            if (c == LAST_C) slot_phase <= ~slot_phase;
        end

    // owner state register
    always_ff @(posedge CLK100MHZ or posedge RESET)
        if (RESET) owner <= NONE;
        else owner <= owner_nxt;

    // grant at slot start (fixed requester first, DMA fills idle slots), release once data is back
    always_comb begin
        owner_nxt = owner;
        if (c == '0)
            owner_nxt = slot_phase ? (cpu_req ? CPU : dma_req ? DMA : NONE)
                                   : (vid_req ? VID : dma_req ? DMA : NONE);
        else if (c == DONE_C)
            owner_nxt = NONE;
        start = (c == '0) && (owner_nxt != NONE);
        done  = (c == DONE_C) && (owner != NONE);
    end

    // select the new owner's access fields; video never writes
    always_comb begin
        issue_we    = (owner_nxt == CPU) ? cpu_we : (owner_nxt == DMA) ? dma_we : 1'b0;
        issue_addr  = (owner_nxt == VID) ? vid_addr : (owner_nxt == CPU) ? cpu_addr :
                      (owner_nxt == DMA) ? dma_addr : '0;
        issue_wdata = (owner_nxt == CPU) ? cpu_wdata : (owner_nxt == DMA) ? dma_wdata : '0;
    end

    // one-cycle registered RAM strobe in c=1; all fields zero when idle
    always_ff @(posedge CLK100MHZ or posedge RESET)
        if (RESET) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            own_we    <= 1'b0;
        end else begin
            ram_en    <= start;
            ram_we    <= start & issue_we;
            ram_addr  <= start ? issue_addr : '0;
            ram_wdata <= start ? issue_wdata : '0;
            if (start) own_we <= issue_we;
        end

    // capture read data and pulse the owner's ack in the same edge
    always_ff @(posedge CLK100MHZ or posedge RESET)
        if (RESET) begin
            vid_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            vid_rdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            vid_ack <= done && (owner == VID);
            cpu_ack <= done && (owner == CPU);
            dma_ack <= done && (owner == DMA);
            if (done && (owner == VID)) vid_rdata <= ram_rdata;
            if (done && (owner == CPU) && !own_we) cpu_rdata <= ram_rdata;
            if (done && (owner == DMA) && !own_we) dma_rdata <= ram_rdata;
        end
endmodule

// File: tb/tb_ram_slot_scheduler.sv
// tb_ram_slot_scheduler: directed checks of slot arbitration, RAM timing, DMA fill-in and reset
module tb_ram_slot_scheduler;
    localparam int SL = 25;

    logic        CLK100MHZ = 1'b0;
    logic        RESET = 1'b1;
    logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [14:0] vid_addr = '0, cpu_addr = '0, dma_addr = '0;
    logic [7:0]  cpu_wdata = '0, dma_wdata = '0;
    logic        vid_ack, cpu_ack, dma_ack, ram_en, ram_we, slot_phase;
    logic [7:0]  vid_rdata, cpu_rdata, dma_rdata, ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic [14:0] ram_addr;
    logic [7:0]  mem [0:32767];
    int          tests = 0, failed = 0;
    int          tb_c;
    logic        tb_ph;

    ram_slot_scheduler dut (
        .CLK100MHZ(CLK100MHZ), .RESET(RESET),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .slot_phase(slot_phase)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // synchronous RAM, one cycle read latency, not reset
    always @(posedge CLK100MHZ)
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end

    // reference slot position
    always @(posedge CLK100MHZ or posedge RESET)
        if (RESET) begin
            tb_c  <= 0;
            tb_ph <= 1'b0;
        end else if (tb_c == SL - 1) begin
            tb_c  <= 0;
            tb_ph <= ~tb_ph;
        end else tb_c <= tb_c + 1;

    task automatic wait_slot(input logic ph, input int cv);
        bit found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge CLK100MHZ);
            found = (tb_ph == ph) && (tb_c == cv);
        end
        if (!found) begin
            tests++; failed++;
            $display("FAIL wait_slot: phase %0d c %0d not reached, got phase %0d c %0d", ph, cv, tb_ph, tb_c);
        end
    endtask

    task automatic test_reset;
        int bad_ph = 0;
        bit seen_en = 0;
        RESET = 1'b1;
        repeat (10) @(negedge CLK100MHZ);
        tests++;
        if ({vid_ack, cpu_ack, dma_ack, ram_en, ram_we, ram_addr, ram_wdata, vid_rdata, cpu_rdata, dma_rdata, slot_phase} !== '0) begin
            failed++;
            $display("FAIL reset_outputs: got en=%b we=%b addr=%h wd=%h acks=%b%b%b ph=%b, required all 0",
                     ram_en, ram_we, ram_addr, ram_wdata, vid_ack, cpu_ack, dma_ack, slot_phase);
        end
        RESET = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge CLK100MHZ);
            if (slot_phase !== (((n / SL) % 2) != 0)) bad_ph++;
            if (ram_en !== 1'b0) seen_en = 1;
        end
        tests++;
        if (bad_ph != 0) begin
            failed++;
            $display("FAIL reset_phase_toggle: %0d cycles with wrong slot_phase, required 0", bad_ph);
        end
        tests++;
        if (seen_en) begin
            failed++;
            $display("FAIL idle_no_ram_en: ram_en seen high, required 0 with no requests");
        end
    endtask

    task automatic test_video_read;
        wait_slot(1, 10);
        vid_req = 1'b1; vid_addr = 15'h1234;
        wait_slot(0, 1);
        tests++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b0, 15'h1234, 8'h00}) begin
            failed++;
            $display("FAIL vid_issue: got en=%b we=%b addr=%h wd=%h, required 1 0 1234 00", ram_en, ram_we, ram_addr, ram_wdata);
        end
        @(negedge CLK100MHZ);
        tests++;
        if (vid_ack !== 1'b0) begin
            failed++;
            $display("FAIL vid_ack_early: got %b at c=2, required 0", vid_ack);
        end
        @(negedge CLK100MHZ);
        tests++;
        if ({vid_ack, vid_rdata} !== {1'b1, 8'h5A}) begin
            failed++;
            $display("FAIL vid_ack_data: got ack=%b data=%h, required 1 5a", vid_ack, vid_rdata);
        end
        vid_req = 1'b0;
        @(negedge CLK100MHZ);
        tests++;
        if (vid_ack !== 1'b0) begin
            failed++;
            $display("FAIL vid_ack_pulse: got %b at c=4, required 0", vid_ack);
        end
    endtask

    task automatic test_interleave;
        wait_slot(1, 10);
        vid_req = 1'b1; vid_addr = 15'h1234;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h3000; cpu_wdata = 8'hA5;
        wait_slot(0, 1);
        tests++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b0, 15'h1234, 8'h00}) begin
            failed++;
            $display("FAIL il_vid_issue: got en=%b we=%b addr=%h wd=%h, required 1 0 1234 00", ram_en, ram_we, ram_addr, ram_wdata);
        end
        wait_slot(0, 3);
        tests++;
        if ({vid_ack, cpu_ack} !== 2'b10) begin
            failed++;
            $display("FAIL il_vid_ack: got vid=%b cpu=%b, required 1 0", vid_ack, cpu_ack);
        end
        vid_req = 1'b0;
        wait_slot(1, 1);
        tests++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 15'h3000, 8'hA5}) begin
            failed++;
            $display("FAIL il_cpu_write: got en=%b we=%b addr=%h wd=%h, required 1 1 3000 a5", ram_en, ram_we, ram_addr, ram_wdata);
        end
        wait_slot(1, 3);
        tests++;
        if ({cpu_ack, vid_ack, cpu_rdata} !== {1'b1, 1'b0, 8'h00}) begin
            failed++;
            $display("FAIL il_cpu_write_ack: got cpu=%b vid=%b rdata=%h, required 1 0 00", cpu_ack, vid_ack, cpu_rdata);
        end
        cpu_we = 1'b0; cpu_wdata = 8'h00;
        wait_slot(0, 1);
        tests++;
        if (ram_en !== 1'b0) begin
            failed++;
            $display("FAIL il_idle_vid_slot: got ram_en=%b, required 0", ram_en);
        end
        wait_slot(1, 3);
        tests++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 8'hA5}) begin
            failed++;
            $display("FAIL il_cpu_readback: got ack=%b rdata=%h, required 1 a5", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_dma_fill;
        logic        we_v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [14:0] ad_v [4] = '{15'h0100, 15'h0101, 15'h0100, 15'h0101};
        logic [7:0]  wd_v [4] = '{8'h11, 8'h22, 8'h00, 8'h00};
        logic [7:0]  rd_v [4] = '{8'h00, 8'h00, 8'h11, 8'h22};
        wait_slot(1, 10);
        dma_req = 1'b1;
        dma_we = we_v[0]; dma_addr = ad_v[0]; dma_wdata = wd_v[0];
        for (int s = 0; s < 4; s++) begin
            wait_slot(logic'(s % 2), 1);
            tests++;
            if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, we_v[s], ad_v[s], wd_v[s]}) begin
                failed++;
                $display("FAIL dma_issue[%0d]: got en=%b we=%b addr=%h wd=%h, required 1 %b %h %h",
                         s, ram_en, ram_we, ram_addr, ram_wdata, we_v[s], ad_v[s], wd_v[s]);
            end
            wait_slot(logic'(s % 2), 3);
            tests++;
            if ({dma_ack, dma_rdata} !== {1'b1, rd_v[s]}) begin
                failed++;
                $display("FAIL dma_ack[%0d]: got ack=%b rdata=%h, required 1 %h", s, dma_ack, dma_rdata, rd_v[s]);
            end
            if (s < 3) begin
                dma_we = we_v[s+1]; dma_addr = ad_v[s+1]; dma_wdata = wd_v[s+1];
            end else dma_req = 1'b0;
        end
    endtask

    task automatic test_dma_starve;
        int n_d = 0, n_vc = 0;
        wait_slot(1, 10);
        vid_req = 1'b1; vid_addr = 15'h1234;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h3000;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0100;
        wait_slot(0, 0);
        for (int n = 0; n < 8 * SL; n++) begin
            @(negedge CLK100MHZ);
            n_d  += int'(dma_ack);
            n_vc += int'(vid_ack) + int'(cpu_ack);
        end
        vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        tests++;
        if (n_d != 0) begin
            failed++;
            $display("FAIL dma_starve: got %0d dma acks, required 0", n_d);
        end
        tests++;
        if (n_vc != 8) begin
            failed++;
            $display("FAIL starve_vid_cpu: got %0d vid+cpu acks, required 8", n_vc);
        end
    endtask

    task automatic test_late_request;
        int en_at = -1, ack_at = -1;
        cpu_we = 1'b0; cpu_addr = 15'h0100;
        wait_slot(1, 1);
        tests++;
        if (ram_en !== 1'b0) begin
            failed++;
            $display("FAIL late_no_issue: got ram_en=%b, required 0", ram_en);
        end
        cpu_req = 1'b1;
        wait_slot(1, 3);
        tests++;
        if (cpu_ack !== 1'b0) begin
            failed++;
            $display("FAIL late_no_grant: got cpu_ack=%b, required 0", cpu_ack);
        end
        for (int n = 1; n <= 100 && ack_at < 0; n++) begin
            @(negedge CLK100MHZ);
            if (ram_en && en_at < 0) en_at = n;
            if (cpu_ack) ack_at = n;
        end
        cpu_req = 1'b0;
        tests++;
        if (en_at != 2 * SL - 2) begin
            failed++;
            $display("FAIL late_ram_en: got ram_en %0d cycles after missed ack point, required %0d", en_at, 2 * SL - 2);
        end
        tests++;
        if ({ack_at, cpu_rdata} !== {2 * SL, 8'h11}) begin
            failed++;
            $display("FAIL late_ack: got ack after %0d cycles rdata=%h, required %0d 11", ack_at, cpu_rdata, 2 * SL);
        end
    endtask

    task automatic test_reset_mid_access;
        int bad_ph = 0, n_ack = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0101;
        wait_slot(1, 1);
        tests++;
        if (ram_en !== 1'b1) begin
            failed++;
            $display("FAIL mid_strobe: got ram_en=%b, required 1", ram_en);
        end
        RESET = 1'b1;
        #1;
        tests++;
        if ({vid_ack, cpu_ack, dma_ack, ram_en, ram_we, ram_addr, ram_wdata, vid_rdata, cpu_rdata, dma_rdata, slot_phase} !== '0) begin
            failed++;
            $display("FAIL mid_reset_outputs: got en=%b addr=%h cpu_rdata=%h vid_rdata=%h ph=%b, required all 0",
                     ram_en, ram_addr, cpu_rdata, vid_rdata, slot_phase);
        end
        repeat (3) begin
            @(negedge CLK100MHZ);
            n_ack += int'(cpu_ack);
        end
        cpu_req = 1'b0;
        RESET = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge CLK100MHZ);
            if (slot_phase !== (((n / SL) % 2) != 0)) bad_ph++;
            n_ack += int'(cpu_ack) + int'(vid_ack) + int'(dma_ack);
        end
        tests++;
        if (n_ack != 0) begin
            failed++;
            $display("FAIL mid_no_ack: got %0d acks, required 0", n_ack);
        end
        tests++;
        if ({bad_ph, cpu_rdata} !== {32'd0, 8'h00}) begin
            failed++;
            $display("FAIL mid_restart: %0d wrong-phase cycles, cpu_rdata=%h, required 0 00", bad_ph, cpu_rdata);
        end
    endtask

    initial begin
        mem[15'h1234] = 8'h5A;
        test_reset;
        test_video_read;
        test_interleave;
        test_dma_fill;
        test_dma_starve;
        test_late_request;
        test_reset_mid_access;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: bench did not finish, %0d tests run, %0d failed", tests, failed);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_slot_scheduler.md
# ram_slot_scheduler

Time-slot scheduler that shares the single-port system RAM between the video fetch path (CRTC/video ULA), the 6502 CPU and the SD-card DMA loader. It sits between those three requesters and the synchronous block RAM in TOP. It reproduces the BBC micro's interleaved access pattern: alternate fixed slots go to video and CPU, and DMA is given only the slots that would otherwise go unused.

## Interface
Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 8, data width.
- SLOT_LEN, 25, cycles per slot. Default gives 2 MHz per requester at 100 MHz. Must be ≥ RAM_LATENCY+3.
- RAM_LATENCY, 1, cycles from the edge that samples ram_en to valid ram_rdata.

Ports:
- CLK100MHZ  in  1  system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- vid_req  in  1  video read request (level).
- vid_addr  in  ADDR_W  video read address.
- vid_ack  out  1  one-cycle done pulse.
- vid_rdata  out  DATA_W  read data; valid from vid_ack onward.
- cpu_req, cpu_we  in  1 each  CPU request and write enable.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle done pulse.
- cpu_rdata  out  DATA_W  CPU read data.
- dma_req, dma_we  in  1 each  DMA request and write enable.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_ack  out  1  one-cycle done pulse.
- dma_rdata  out  DATA_W  DMA read data.
- ram_en, ram_we  out  1 each  RAM strobe and write enable, registered.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- ram_rdata  in  DATA_W  RAM read data.
- slot_phase  out  1  0 = video slot, 1 = CPU slot.

## Operation
- Slot cycle counter c runs 0..SLOT_LEN-1. slot_phase toggles when c wraps to 0.
- Owner state: NONE, VID, CPU or DMA. The owner is decided only in cycle c=0:
  - phase 0: VID if vid_req, else DMA if dma_req, else NONE.
  - phase 1: CPU if cpu_req, else DMA if dma_req, else NONE.
- Access issue: for owner ≠ NONE, ram_en=1 for exactly one cycle (c=1), carrying the owner's addr, we and wdata. ram_we is forced to 0 for VID. All ram_* outputs are 0 whenever ram_en=0.
- Read data: for reads, ram_rdata is captured into the owner's rdata register. That register holds until the owner's next read completes. Writes leave rdata unchanged.
- Acknowledge: the owner's ack pulses for one cycle. The owner then returns to NONE until the next c=0.
- Requester contract: req, addr, we and wdata are held stable from req rise through the ack cycle. In the cycle after ack the requester either deasserts req or presents a new request.
- A request that rises after c=0 waits for the next eligible slot. There is no mid-slot grant.
- DMA is strictly background. With vid_req and cpu_req continuously high, DMA is never granted; starvation is accepted by design.
- Reset mid-slot: the pending access is abandoned and no ack is issued. A RAM write already strobed is committed, because the RAM is not reset.

## Timing
- Reset values: c=0, slot_phase=0, owner=NONE, all acks 0, ram_en/ram_we 0, ram_addr/ram_wdata 0, all rdata registers 0.
- The first slot after reset release is a video slot.
- Request sampled at c=0.
- ram_en high in c=1.
- ram_rdata valid in c=1+RAM_LATENCY, registered into rdata.
- ack high in c=2+RAM_LATENCY, with rdata already valid.
- Worst-case latency from req rise to ack: 2·SLOT_LEN + 2 + RAM_LATENCY − 1 cycles, for a request rising just after its own slot's c=0.
- The SLOT_LEN ≥ RAM_LATENCY+3 constraint guarantees requester updates settle before the next c=0.

## Test plan
- Reset: hold RESET for 10 cycles → all outputs 0 and slot_phase=0. After release, slot_phase toggles every SLOT_LEN cycles, and no ram_en occurs while all reqs are low.
- Video read: ram model holds 0x5A at 0x1234; vid_req with vid_addr=0x1234 before a phase-0 c=0 → ram_en, ram_we=0 at c=1; vid_ack at c=2+RAM_LATENCY; vid_rdata=0x5A.
- Interleave: cpu write 0x3000←0xA5 and vid_req both held → accesses land in alternate slots with no overlap. A following CPU read of 0x3000 returns cpu_rdata=0xA5.
- DMA fill-in: dma_req held with vid_req=cpu_req=0 → dma_ack once per slot in both phases. With vid_req and cpu_req both held high for 8 slots → dma_ack stays 0.
- Late request: cpu_req rises at c=1 of a CPU slot → no grant that slot. ram_en at c=1 of the next CPU slot; cpu_ack 2·SLOT_LEN cycles after the missed slot's ack point.
- Reset mid-access: assert RESET at c=1 of a CPU read → no cpu_ack; all state returns to its reset values; after release, operation restarts from phase 0.
